// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and helpers for the FIFO write-port arbiter and
//                any future scheduler built around rr_select.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM states, one bit wide.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Largest requester count any client of this package supports.
    localparam int c_MAX_REQ   = 8;
    localparam int c_MAX_IDX_W = 3;

    // Result of a round-robin pick: whether anything was requesting, and who.
    typedef struct packed {
        logic                   found;
        logic [c_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Behavioural round-robin pick: first set bit of req, starting at rr_ptr
    // and wrapping at num_req. Useful as a golden reference next to the
    // structural rr_select, or for small schedulers that do not need it.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_REQ-1:0]   req,
        input logic [c_MAX_IDX_W-1:0] rr_ptr,
        input int                     num_req
    );
        rr_pick_t r;
        int       j;
        r = '0;
        // Walk from the far end back toward rr_ptr so the last hit written
        // is the nearest one in rotation order.
        for (int k = num_req - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % num_req;
            if (req[j]) begin
                r.found = 1'b1;
                r.idx   = c_MAX_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin selector. Rotates the request
//                vector so the pointer lands on bit 0, priority-encodes the
//                lowest set bit, then adds the pointer back modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int SUM_W = IDX_W + 1;

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;

    // Doubling the vector turns a rotate into a plain right shift.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N'(w_dbl >> i_ptr);

    // Lowest set bit of the rotated vector = distance from the pointer.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Un-rotate: add the pointer back and fold once, since both terms are < N.
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= SUM_W'(N)) ? IDX_W'(w_sum - SUM_W'(N))
                                          : w_sum[IDX_W-1:0];
    assign o_found = |i_req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one async_fifo write port among
//                NUM_REQ producers. Grants bursts of up to MAX_BURST words,
//                stalls on fifo_full and rotates ownership at burst end.
//                Supported ranges: NUM_REQ 2..8, MAX_BURST 1..16.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    owner_idx,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [NUM_REQ-1:0]    w_sel_onehot;
    logic                  w_owner_req;
    logic                  w_owner_last;
    logic                  w_accept;
    logic                  w_cnt_max;
    logic                  w_burst_end;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_ack;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    // Next owner candidate, searched from the round-robin pointer upward.
    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_sel_idx)
    );

    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;

    // Owner-side qualifiers. busy gates accept so nothing is acked in IDLE,
    // where r_owner is parked at 0 and must not leak an ack to requester 0.
    assign w_owner_req  = req[r_owner];
    assign w_owner_last = req_last[r_owner];
    assign w_accept     = w_owner_req & ~fifo_full & r_busy;
    assign w_cnt_max    = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

    // A burst ends on its last word, on the word-count limit, or when the
    // owner withdraws. A stalled owner (fifo_full) keeps the grant.
    assign w_burst_end  = r_busy & ((w_accept & (w_owner_last | w_cnt_max))
                                    | ~w_owner_req);

    // Pointer moves one past the finishing owner, wrapping at NUM_REQ.
    assign w_ptr_next   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : r_owner + 1'b1;

    // Split the packed data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Holds IDLE/BURST; reset drops any burst in progress.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // IDLE waits for any request; BURST returns to IDLE at burst end,
    // which leaves exactly one bubble cycle before the next grant.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = BURST;
                end
            end
            BURST: begin
                if (w_burst_end) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // Ack goes only to the grant holder, so it is one-hot or zero.
    always_comb begin
        w_ack = '0;
        if (w_accept) begin
            w_ack = r_grant;
        end
    end

    // ------------------------------------------------------------------
    // Grant, owner, busy and round-robin pointer
    // ------------------------------------------------------------------
    // Captures the selection on leaving IDLE; clears it and advances the
    // pointer when the burst ends.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= '0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_grant <= w_sel_onehot;
                r_owner <= w_sel_idx;
                r_busy  <= 1'b1;
            end
        end else if (w_burst_end) begin
            r_grant  <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Burst word counter
    // ------------------------------------------------------------------
    // Counts accepted words of the current burst; holds across full stalls
    // and restarts at zero for every new grant.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if ((r_state == IDLE) || w_burst_end) begin
            r_burst_cnt <= '0;
        end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------
    assign ack          = w_ack;
    assign fifo_wr_en   = |w_ack;
    assign fifo_data_in = w_words[r_owner];
    assign grant        = r_grant;
    assign owner_idx    = r_owner;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Random producers,
//                a queue-based FIFO sink and a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic              wr_clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     grant;
    logic [1:0]        owner_idx;
    logic              busy;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk       (wr_clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .ack          (ack),
        .grant        (grant),
        .owner_idx    (owner_idx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 when idle), words granted so far in
    // the burst, and the requester to start searching from.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;

    // Producers
    bit          p_req  [NR];
    bit          p_last [NR];
    logic [7:0]  p_word [NR];

    // Stimulus knobs (percent unless noted)
    logic [NR-1:0] k_mask;
    int k_start, k_last, k_drop, k_full, k_rst_pm, k_drain;

    // FIFO sink and scoreboard
    logic [7:0] q_fifo [$];
    logic [7:0] q_exp  [$];
    logic [7:0] ack_words [$];
    int         ack_cycles [$];
    bit         force_full;
    int         cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i]                = p_req[i];
            req_last[i]           = p_last[i];
            req_data[i*DW +: DW]  = p_word[i];
        end
        fifo_full = force_full || (q_fifo.size() >= DEPTH);
    endtask

    // One clock: check outputs at negedge, advance model and producers
    // just after posedge, then drive the next inputs.
    task automatic step();
        logic [NR-1:0] e_grant;
        logic [NR-1:0] e_ack;
        logic          acc;
        int            o;
        int            pick;
        logic [7:0]    w;

        @(negedge wr_clk);
        o       = m_owner;
        e_grant = '0;
        if (o >= 0) e_grant[o] = 1'b1;
        acc   = (o >= 0) && req[o] && !fifo_full;
        e_ack = acc ? e_grant : '0;

        check_val("grant", grant, e_grant);
        check_val("owner_idx", owner_idx, (o < 0) ? 0 : o);
        check_val("busy", busy, o >= 0);
        check_val("ack", ack, e_ack);
        check_val("wr_en", fifo_wr_en, acc);
        if (acc) begin
            check_val("data", fifo_data_in, p_word[o]);
            q_exp.push_back(p_word[o]);
            ack_words.push_back(p_word[o]);
            ack_cycles.push_back(cyc);
        end
        if (fifo_wr_en) q_fifo.push_back(fifo_data_in);
        if (q_fifo.size() > 0 && $urandom_range(0, 99) < k_drain) begin
            w = q_fifo.pop_front();
            if (q_exp.size() > 0) check_val("fifo_order", w, q_exp.pop_front());
        end

        @(posedge wr_clk);
        #1;
        // Model the edge using the inputs that were present at it.
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < NR; k++)
                if (pick < 0 && req[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
            m_owner = pick;
            m_cnt   = 0;
        end else if (!req[m_owner] || (acc && (req_last[m_owner] || m_cnt + 1 == MB))) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
            m_cnt   = 0;
        end else if (acc) begin
            m_cnt++;
        end

        for (int i = 0; i < NR; i++) begin
            if (acc && o == i) begin
                p_word[i]++;
                p_last[i] = ($urandom_range(0, 99) < k_last);
                p_req[i]  = k_mask[i] && ($urandom_range(0, 99) < k_start);
            end else if (p_req[i]) begin
                if ($urandom_range(0, 99) < k_drop) p_req[i] = 1'b0;
            end else begin
                p_req[i] = k_mask[i] && ($urandom_range(0, 99) < k_start);
                if (p_req[i]) p_last[i] = ($urandom_range(0, 99) < k_last);
            end
        end
        rst        = ($urandom_range(0, 999) < k_rst_pm);
        force_full = ($urandom_range(0, 99) < k_full);
        drive();
        cyc++;
    endtask

    initial begin
        k_mask = '1; k_start = 100; k_last = 0; k_drop = 0;
        k_full = 0;  k_rst_pm = 0;  k_drain = 50;
        force_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            p_req[i]  = 1'b1;
            p_last[i] = 1'b0;
            p_word[i] = 8'(i * 64);
        end
        rst = 1'b1;
        drive();

        // Reset for two edges with every requester asserting.
        @(posedge wr_clk);
        #1;
        step();
        step();
        check_val("first_grant", grant, 4'b0001);
        repeat (20) step();

        // Quiesce, then a lone requester 2 streaming 0xA0.. with no last.
        k_mask = '0; k_drop = 100;
        repeat (3) step();
        p_word[2] = 8'hA0; p_last[2] = 1'b0;
        k_mask = 4'b0100; k_drop = 0; k_last = 0; k_start = 100;
        rst = 1'b1;
        drive();
        step();
        ack_words.delete();
        ack_cycles.delete();
        repeat (10) step();
        check_val("burst_acks", ack_words.size() >= 5, 1);
        if (ack_words.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_val("burst_word", ack_words[k], 8'hA0 + k);
            check_val("burst_span", ack_cycles[3] - ack_cycles[0], 3);
            check_val("bubble_gap", ack_cycles[4] - ack_cycles[3], 2);
        end

        // Random multi-requester traffic with stalls, withdrawals and resets.
        k_mask = '1; k_start = 60; k_last = 25; k_drop = 3;
        k_full = 20; k_rst_pm = 5;
        repeat (3000) step();

        // Drain: stop producers and empty the FIFO.
        k_mask = '0; k_drop = 100; k_full = 0; k_rst_pm = 0; k_drain = 100;
        repeat (40) step();
        check_val("sb_fifo_left", q_fifo.size(), 0);
        check_val("sb_exp_left", q_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
